// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM states,
// opcodes and the ALUControl codes that the ALU also decodes.
package mc_pkg;

   localparam int STATE_WIDTH = 4;

   typedef enum logic [STATE_WIDTH-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD  = 2'b00,
      ALUOP_SUB  = 2'b01,
      ALUOP_FUNC = 2'b10
   } aluop_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus the instruction's funct fields onto an ALUControl code and
// flags funct3 values the ALU does not implement.
module alu_decoder
   import mc_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alucontrol,
   output logic       illegal_f3
);

   always_comb begin
      alucontrol = ALU_ADD;
      illegal_f3 = 1'b0;
      case (aluop)
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNC: begin
            case (funct3)
               // only R-type (op[5]=1) can encode sub; addi with imm[10]=1 stays add
               3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alucontrol = ALU_SLT;
               3'b110:  alucontrol = ALU_OR;
               3'b111:  alucontrol = ALU_AND;
               default: illegal_f3 = 1'b1;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM: sequences each instruction through its
// states and drives datapath selects, write enables and ALUControl.
module mc_control_unit
   import mc_pkg::*;
#(
   parameter int STATE_W = STATE_WIDTH
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       illegal
);

   logic [STATE_W-1:0] state_reg;
   state_t             state;
   state_t             state_next;

   aluop_t aluop;
   logic   pcupdate, branch, taken;
   logic   irwrite_s, regwrite_s, memwrite_s, illegal_s;
   logic   illegal_f3;

   assign state = state_t'(state_reg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= STATE_W'(S_FETCH);
      else       state_reg <= STATE_W'(state_next);
   end

   always_comb begin
      state_next = S_FETCH;
      aluop      = ALUOP_ADD;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      pcupdate   = 1'b0;
      branch     = 1'b0;
      irwrite_s  = 1'b0;
      regwrite_s = 1'b0;
      memwrite_s = 1'b0;
      illegal_s  = 1'b0;
      case (state)
         S_FETCH: begin
            state_next = S_DECODE;
            irwrite_s  = 1'b1;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            pcupdate   = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_RTYPE:          state_next = S_EXECR;
               OP_ITYPE:          state_next = S_EXECI;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
               default: begin
                  state_next = S_FETCH;
                  illegal_s  = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
         end
         S_MEMREAD: begin
            state_next = S_MEMWB;
            AdrSrc     = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc  = 2'b01;
            regwrite_s = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            memwrite_s = 1'b1;
         end
         S_EXECR, S_EXECI: begin
            state_next = S_ALUWB;
            ALUSrcA    = 2'b10;
            ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
            aluop      = ALUOP_FUNC;
            illegal_s  = illegal_f3;
         end
         S_ALUWB: begin
            regwrite_s = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA   = 2'b10;
            aluop     = ALUOP_SUB;
            branch    = 1'b1;
            illegal_s = (funct3 != F3_BEQ) && (funct3 != F3_BNE);
         end
         S_JAL: begin
            state_next = S_ALUWB;
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            pcupdate   = 1'b1;
         end
         default: state_next = S_FETCH;
      endcase
   end

   always_comb begin
      case (funct3)
         F3_BEQ:  taken = zero;
         F3_BNE:  taken = ~zero;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      case (op)
         OP_STORE:  ImmSrc = IMM_S;
         OP_BRANCH: ImmSrc = IMM_B;
         OP_JAL:    ImmSrc = IMM_J;
         default:   ImmSrc = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop      (aluop),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .op5        (op[5]),
      .alucontrol (ALUControl),
      .illegal_f3 (illegal_f3)
   );

   // reset gates the enables combinationally so they drop in the cycle reset rises
   assign PCWrite  = ~reset & (pcupdate | (branch & taken));
   assign IRWrite  = ~reset & irwrite_s;
   assign RegWrite = ~reset & regwrite_s;
   assign MemWrite = ~reset & memwrite_s;
   assign illegal  = ~reset & illegal_s;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class cycle by
// cycle and compares the full output vector against hand-derived values.
module tb_mc_control_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = 7'b0000011;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;

   int tests_run = 0;
   int tests_failed = 0;

   // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,illegal}
   logic [14:0] obs;
   assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUControl, illegal};

   localparam logic [14:0] E_FETCH   = 15'b1_0_0_1_0_10_00_10_000_0;
   localparam logic [14:0] E_RST     = 15'b0_0_0_0_0_10_00_10_000_0;
   localparam logic [14:0] E_DECODE  = 15'b0_0_0_0_0_00_01_01_000_0;
   localparam logic [14:0] E_MEMADR  = 15'b0_0_0_0_0_00_10_01_000_0;
   localparam logic [14:0] E_MEMREAD = 15'b0_1_0_0_0_00_00_00_000_0;
   localparam logic [14:0] E_MEMWB   = 15'b0_0_0_0_1_01_00_00_000_0;
   localparam logic [14:0] E_MEMWR   = 15'b0_1_1_0_0_00_00_00_000_0;
   localparam logic [14:0] E_EXECR   = 15'b0_0_0_0_0_00_10_00_000_0;
   localparam logic [14:0] E_EXECI   = 15'b0_0_0_0_0_00_10_01_000_0;
   localparam logic [14:0] E_ALUWB   = 15'b0_0_0_0_1_00_00_00_000_0;
   localparam logic [14:0] E_BRANCH  = 15'b0_0_0_0_0_00_10_00_001_0;
   localparam logic [14:0] E_JAL     = 15'b1_0_0_0_0_00_01_10_000_0;

   mc_control_unit #(.STATE_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .zero       (zero),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   // Pulses reset, loads the instruction fields and leaves the bench 1 ns
   // into the first FETCH cycle.
   task automatic start_instr(input logic [6:0] o, input logic [2:0] f3,
                              input logic f7, input logic z);
      @(negedge clk);
      reset = 1'b1;
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      op = 7'b0000011;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         tests_run++;
         if (obs !== E_RST) begin
            tests_failed++;
            $display("FAIL reset_hold cyc%0d: got %b want %b", i, obs, E_RST);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      tests_run++;
      if (obs !== E_FETCH) begin
         tests_failed++;
         $display("FAIL reset_release_fetch: got %b want %b", obs, E_FETCH);
      end
      @(negedge clk); #1;
      tests_run++;
      if (obs !== E_DECODE) begin
         tests_failed++;
         $display("FAIL reset_then_decode: got %b want %b", obs, E_DECODE);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_load();
      logic [14:0] exp_seq [6];
      exp_seq = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, E_FETCH};
      start_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         tests_run++;
         if (obs !== exp_seq[i]) begin
            tests_failed++;
            $display("FAIL lw cyc%0d: got %b want %b", i, obs, exp_seq[i]);
         end
      end
      tests_run++;
      if (ImmSrc !== 2'b00) begin
         tests_failed++;
         $display("FAIL lw_immsrc: got %b want 00", ImmSrc);
      end
      $display("[TB] lw sequence checked");
   endtask

   task automatic test_store();
      logic [14:0] exp_seq [5];
      exp_seq = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH};
      start_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         tests_run++;
         if (obs !== exp_seq[i]) begin
            tests_failed++;
            $display("FAIL sw cyc%0d: got %b want %b", i, obs, exp_seq[i]);
         end
      end
      tests_run++;
      if (ImmSrc !== 2'b01) begin
         tests_failed++;
         $display("FAIL sw_immsrc: got %b want 01", ImmSrc);
      end
      $display("[TB] sw sequence checked");
   endtask

   task automatic test_alu_ops();
      // {op, funct3, funct7b5, ALUControl, illegal}
      logic [14:0] vec [6];
      logic [14:0] exp_seq [4];
      logic [6:0]  o;
      logic [2:0]  f3, ctl;
      logic        f7, ill;
      vec = '{{7'b0110011, 3'b000, 1'b1, 3'b001, 1'b0},   // sub
              {7'b0110011, 3'b000, 1'b0, 3'b000, 1'b0},   // add
              {7'b0110011, 3'b010, 1'b0, 3'b101, 1'b0},   // slt
              {7'b0110011, 3'b001, 1'b0, 3'b000, 1'b1},   // sll: unsupported
              {7'b0010011, 3'b000, 1'b1, 3'b000, 1'b0},   // addi, imm bit ignored
              {7'b0010011, 3'b110, 1'b0, 3'b011, 1'b0}};  // ori
      for (int v = 0; v < 6; v++) begin
         {o, f3, f7, ctl, ill} = vec[v];
         exp_seq[0] = E_FETCH;
         exp_seq[1] = E_DECODE;
         exp_seq[2] = (o[5] ? E_EXECR : E_EXECI) | {10'b0, ctl, ill};
         exp_seq[3] = E_ALUWB;
         start_instr(o, f3, f7, 1'b0);
         for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            tests_run++;
            if (obs !== ((i == 4) ? E_FETCH : exp_seq[i])) begin
               tests_failed++;
               $display("FAIL alu v%0d cyc%0d: got %b want %b", v, i, obs,
                        (i == 4) ? E_FETCH : exp_seq[i]);
            end
         end
         $display("[TB] alu op=%b f3=%b f7=%b -> ctl %b ill %b", o, f3, f7, ctl, ill);
      end
   endtask

   task automatic test_branch();
      // {funct3, zero, PCWrite, illegal}
      logic [5:0]  vec [5];
      logic [14:0] exp_b;
      logic [2:0]  f3;
      logic        z, pcw, ill;
      vec = '{{3'b000, 1'b1, 1'b1, 1'b0},
              {3'b000, 1'b0, 1'b0, 1'b0},
              {3'b001, 1'b1, 1'b0, 1'b0},
              {3'b001, 1'b0, 1'b1, 1'b0},
              {3'b100, 1'b1, 1'b0, 1'b1}};
      for (int v = 0; v < 5; v++) begin
         {f3, z, pcw, ill} = vec[v];
         exp_b = E_BRANCH | {pcw, 13'b0, ill};
         start_instr(7'b1100011, f3, 1'b0, z);
         tests_run++;
         if (ImmSrc !== 2'b10) begin
            tests_failed++;
            $display("FAIL br_immsrc: got %b want 10", ImmSrc);
         end
         @(negedge clk); #1;
         tests_run++;
         if (obs !== E_DECODE) begin
            tests_failed++;
            $display("FAIL br v%0d decode: got %b want %b", v, obs, E_DECODE);
         end
         @(negedge clk); #1;
         tests_run++;
         if (obs !== exp_b) begin
            tests_failed++;
            $display("FAIL br v%0d branch: got %b want %b", v, obs, exp_b);
         end
         @(negedge clk); #1;
         tests_run++;
         if (obs !== E_FETCH) begin
            tests_failed++;
            $display("FAIL br v%0d refetch: got %b want %b", v, obs, E_FETCH);
         end
         $display("[TB] branch f3=%b zero=%b -> PCWrite %b ill %b", f3, z, pcw, ill);
      end
   endtask

   task automatic test_jal();
      logic [14:0] exp_seq [5];
      exp_seq = '{E_FETCH, E_DECODE, E_JAL, E_ALUWB, E_FETCH};
      start_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         tests_run++;
         if (obs !== exp_seq[i]) begin
            tests_failed++;
            $display("FAIL jal cyc%0d: got %b want %b", i, obs, exp_seq[i]);
         end
      end
      tests_run++;
      if (ImmSrc !== 2'b11) begin
         tests_failed++;
         $display("FAIL jal_immsrc: got %b want 11", ImmSrc);
      end
      $display("[TB] jal sequence checked");
   endtask

   task automatic test_illegal_op();
      logic [6:0] ops [2];
      ops = '{7'b1111111, 7'b0110111};
      for (int v = 0; v < 2; v++) begin
         start_instr(ops[v], 3'b000, 1'b0, 1'b0);
         @(negedge clk); #1;
         tests_run++;
         if (obs !== (E_DECODE | 15'd1)) begin
            tests_failed++;
            $display("FAIL illop %b decode: got %b want %b", ops[v], obs, E_DECODE | 15'd1);
         end
         @(negedge clk); #1;
         tests_run++;
         if (obs !== E_FETCH) begin
            tests_failed++;
            $display("FAIL illop %b refetch: got %b want %b", ops[v], obs, E_FETCH);
         end
         $display("[TB] illegal op %b checked", ops[v]);
      end
   endtask

   task automatic test_reset_mid_store();
      start_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      tests_run++;
      if (obs !== E_MEMWR) begin
         tests_failed++;
         $display("FAIL midrst memwrite: got %b want %b", obs, E_MEMWR);
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if (obs !== E_RST) begin
         tests_failed++;
         $display("FAIL midrst drop: got %b want %b", obs, E_RST);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      tests_run++;
      if (obs !== E_FETCH) begin
         tests_failed++;
         $display("FAIL midrst fetch: got %b want %b", obs, E_FETCH);
      end
      $display("[TB] reset during MEMWRITE checked");
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_alu_ops();
      test_branch();
      test_jal();
      test_illegal_op();
      test_reset_mid_store();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
